// File: rtl/spi_mst_pkg.sv
// spi_mst_pkg: shared constants and types for the memory-mapped SPI master.
//   - register byte offsets within the 256-byte block
//   - CTRL / STATUS bit positions
//   - FSM state type and encodings
//   - MAX_LEN and helpers that map programmed LEN / DIV onto effective values
package spi_mst_pkg;

  localparam int unsigned MAX_LEN = 16;

  // Register offsets
  localparam logic [7:0] OfsCtrl   = 8'h00;
  localparam logic [7:0] OfsDiv    = 8'h04;
  localparam logic [7:0] OfsTxData = 8'h08;
  localparam logic [7:0] OfsRxData = 8'h0C;
  localparam logic [7:0] OfsStatus = 8'h10;

  // CTRL bits
  localparam int unsigned CtrlCsMan  = 0;
  localparam int unsigned CtrlAutoCs = 1;
  localparam int unsigned CtrlIe     = 2;
  localparam int unsigned CtrlLenLsb = 8;
  localparam int unsigned CtrlLenMsb = 12;

  // STATUS bits
  localparam int unsigned StatBusy = 0;
  localparam int unsigned StatDone = 1;
  localparam int unsigned StatOvr  = 2;

  // FSM states
  typedef logic [2:0] state_t;
  localparam state_t StIdle  = 3'd0;
  localparam state_t StSetup = 3'd1;
  localparam state_t StSckHi = 3'd2;
  localparam state_t StSckLo = 3'd3;
  localparam state_t StHold  = 3'd4;

  // LEN of 0 or above MAX_LEN runs a full-width frame.
  function automatic logic [4:0] eff_len(input logic [4:0] len);
    if (len == 5'd0 || len > 5'(MAX_LEN)) begin
      return 5'(MAX_LEN);
    end
    return len;
  endfunction

  // A divider of 0 would never tick; run it as 1.
  function automatic logic [7:0] eff_div(input logic [7:0] div);
    return (div == 8'd0) ? 8'd1 : div;
  endfunction

endpackage

// File: rtl/spi_master_mmio_if.sv
// spi_master_mmio_if: PicoRV32 native memory bus bundle.
//   mem_valid / mem_addr / mem_wdata / mem_wstrb : request from the CPU side
//   mem_ready / mem_rdata                        : one-cycle response from the peripheral
// Modports: master (CPU / bench side), slave (peripheral side).
interface spi_master_mmio_if;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid,
    output mem_addr,
    output mem_wdata,
    output mem_wstrb,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_valid,
    input  mem_addr,
    input  mem_wdata,
    input  mem_wstrb,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/spi_clk_div.sv
// spi_clk_div: phase timer for the SPI FSM.
//   clk, resetn : clock, synchronous active-low reset
//   i_start     : load i_div and begin counting (frame start)
//   i_en        : count while high (FSM busy)
//   i_div       : effective half-period D (>= 1), latched on i_start
//   o_tick      : one-cycle pulse at the end of every D-cycle phase; the
//                 counter reloads itself so back-to-back phases stay D long
module spi_clk_div (
  input  logic       clk,
  input  logic       resetn,
  input  logic       i_start,
  input  logic       i_en,
  input  logic [7:0] i_div,
  output logic       o_tick
);

  logic [7:0] r_load;
  logic [7:0] r_cnt;

  assign o_tick = i_en & (r_cnt == 8'd0);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_load <= 8'd1;
      r_cnt  <= 8'd0;
    end else if (i_start) begin
      r_load <= i_div;
      r_cnt  <= i_div - 8'd1;
    end else if (o_tick) begin
      r_cnt <= r_load - 8'd1;
    end else if (i_en) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

endmodule

// File: rtl/spi_master_mmio.sv
// spi_master_mmio: memory-mapped SPI master (mode 0, MSB first, 1..16-bit frames).
//   clk, resetn : clock, synchronous active-low reset
//   bus         : PicoRV32 native bus (slave modport), decoded on mem_addr[31:8]
//   spi_cs      : chip select, active low
//   spi_sck     : serial clock, idle low
//   spi_mosi    : serial data out
//   spi_miso    : serial data in
//   irq         : DONE & IE, registered (only with SPI_MST_IRQ_EN defined)
// Optional feature macro: SPI_MST_IRQ_EN adds the irq port and CTRL[2] IE.
module spi_master_mmio
  import spi_mst_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
  parameter logic [7:0]  DEFAULT_DIV = 8'd8,
  parameter logic [4:0]  DEFAULT_LEN = 5'd16
) (
  input  logic                clk,
  input  logic                resetn,
  spi_master_mmio_if.slave    bus,
  output logic                spi_cs,
  output logic                spi_sck,
  output logic                spi_mosi,
  input  logic                spi_miso
`ifdef SPI_MST_IRQ_EN
  ,output logic               irq
`endif
);

  // Bus decode
  logic        w_sel, w_acc, w_wr, w_rd;
  logic [7:0]  w_ofs;
  logic        w_unused_wdata;

  // Registers
  logic        r_ready;
  logic [31:0] r_rdata;
  logic        r_cs_man, r_auto_cs;
  logic [4:0]  r_len;
  logic [7:0]  r_div;
  logic        r_done, r_ovr;
  logic        w_done_d, w_ovr_d;
  logic        w_ie;
  logic [31:0] w_rmux;

  // Frame engine
  state_t      r_state;
  logic [15:0] r_tx, r_rx, r_rxdata;
  logic [4:0]  r_bitcnt;
  logic        r_mosi;
  logic        w_busy, w_tx_wr, w_start, w_tick, w_frame_done;
  logic [4:0]  w_len;
  logic [7:0]  w_div;
  logic [15:0] w_tx_align;

  assign w_sel = bus.mem_valid & (bus.mem_addr[31:8] == BASE_ADDR[31:8]);
  // Accept only when not already acknowledging: ready never stays high twice.
  assign w_acc = w_sel & ~r_ready;
  assign w_wr  = w_acc & (|bus.mem_wstrb);
  assign w_rd  = w_acc & ~(|bus.mem_wstrb);
  assign w_ofs = bus.mem_addr[7:0];
  assign w_unused_wdata = ^bus.mem_wdata[31:16];

  assign w_busy       = (r_state != StIdle);
  assign w_tx_wr      = w_wr & (w_ofs == OfsTxData);
  assign w_start      = w_tx_wr & ~w_busy;
  assign w_frame_done = (r_state == StHold) & w_tick;

  assign w_len = eff_len(r_len);
  assign w_div = eff_div(r_div);
  // Left-align the frame so its MSB always sits at bit 15.
  assign w_tx_align = bus.mem_wdata[15:0] << (5'd16 - w_len);

  spi_clk_div u_clk_div (
    .clk     (clk),
    .resetn  (resetn),
    .i_start (w_start),
    .i_en    (w_busy),
    .i_div   (w_div),
    .o_tick  (w_tick)
  );

  // Sticky flags: a set in the same cycle as a clear wins.
  always_comb begin
    w_done_d = r_done;
    if (w_frame_done) begin
      w_done_d = 1'b1;
    end else if (w_start || (w_rd && w_ofs == OfsRxData) ||
                 (w_wr && w_ofs == OfsStatus && bus.mem_wdata[StatDone])) begin
      w_done_d = 1'b0;
    end
  end

  always_comb begin
    w_ovr_d = r_ovr;
    if (w_tx_wr && w_busy) begin
      w_ovr_d = 1'b1;
    end else if (w_wr && w_ofs == OfsStatus && bus.mem_wdata[StatOvr]) begin
      w_ovr_d = 1'b0;
    end
  end

  always_comb begin
    w_rmux = 32'd0;
    case (w_ofs)
      OfsCtrl:   w_rmux = {19'd0, r_len, 5'd0, w_ie, r_auto_cs, r_cs_man};
      OfsDiv:    w_rmux = {24'd0, r_div};
      OfsRxData: w_rmux = {16'd0, r_rxdata};
      OfsStatus: w_rmux = {29'd0, r_ovr, r_done, w_busy};
      default:   w_rmux = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ready   <= 1'b0;
      r_rdata   <= 32'd0;
      r_cs_man  <= 1'b0;
      r_auto_cs <= 1'b1;
      r_len     <= DEFAULT_LEN;
      r_div     <= DEFAULT_DIV;
      r_done    <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      r_ready <= w_acc;
      r_rdata <= w_rd ? w_rmux : 32'd0;
      r_done  <= w_done_d;
      r_ovr   <= w_ovr_d;
      if (w_wr && w_ofs == OfsCtrl) begin
        r_cs_man  <= bus.mem_wdata[CtrlCsMan];
        r_auto_cs <= bus.mem_wdata[CtrlAutoCs];
        r_len     <= bus.mem_wdata[CtrlLenMsb:CtrlLenLsb];
      end
      if (w_wr && w_ofs == OfsDiv) begin
        r_div <= bus.mem_wdata[7:0];
      end
    end
  end

  // Frame FSM. r_bitcnt counts bits still to be sampled on a rising SCK.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state  <= StIdle;
      r_tx     <= 16'd0;
      r_rx     <= 16'd0;
      r_rxdata <= 16'd0;
      r_bitcnt <= 5'd0;
      r_mosi   <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_start) begin
            r_state  <= StSetup;
            r_tx     <= w_tx_align;
            r_mosi   <= w_tx_align[15];
            r_bitcnt <= w_len;
            r_rx     <= 16'd0;
          end
        end
        StSetup: begin
          if (w_tick) begin
            r_state <= StSckHi;
            r_rx    <= {r_rx[14:0], spi_miso};
          end
        end
        StSckHi: begin
          if (w_tick) begin
            r_state  <= StSckLo;
            r_bitcnt <= r_bitcnt - 5'd1;
            if (r_bitcnt > 5'd1) begin
              r_tx   <= {r_tx[14:0], 1'b0};
              r_mosi <= r_tx[14];
            end
          end
        end
        StSckLo: begin
          if (w_tick) begin
            if (r_bitcnt != 5'd0) begin
              r_state <= StSckHi;
              r_rx    <= {r_rx[14:0], spi_miso};
            end else begin
              r_state <= StHold;
            end
          end
        end
        StHold: begin
          if (w_tick) begin
            r_state  <= StIdle;
            r_rxdata <= r_rx;
            r_mosi   <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

`ifdef SPI_MST_IRQ_EN
  logic r_ie, r_irq, w_ie_d;

  always_comb begin
    w_ie_d = r_ie;
    if (w_wr && w_ofs == OfsCtrl) begin
      w_ie_d = bus.mem_wdata[CtrlIe];
    end
  end

  // Built from next-state values so irq tracks DONE edge-for-edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ie  <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      r_ie  <= w_ie_d;
      r_irq <= w_done_d & w_ie_d;
    end
  end

  assign w_ie = r_ie;
  assign irq  = r_irq;
`else
  assign w_ie = 1'b0;
`endif

  assign bus.mem_ready = r_ready;
  assign bus.mem_rdata = r_rdata;
  assign spi_sck       = (r_state == StSckHi);
  assign spi_mosi      = r_mosi;
  assign spi_cs        = ~(r_cs_man | (r_auto_cs & w_busy));

endmodule
